// File: rtl/hazard_ctrl.sv
// Hazard control for the 5-stage MIPS pipeline: stall, bubble and forwarding selects plus HI/LO busy tracking.
// Build option HAZARD_FWD_EN: when defined, forwarding is enabled; otherwise every match stalls and all fwd_* are 0.
module hazard_ctrl #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [4:0] rs_d,
   input  logic [4:0] rt_d,
   input  logic [4:0] a3_d,
   input  logic [1:0] tuse_rs,
   input  logic [1:0] tuse_rt,
   input  logic [2:0] res_d,
   input  logic [1:0] md_op_d,
   input  logic       md_use_d,
   output logic       stall,
   output logic [1:0] fwd_rs_d,
   output logic [1:0] fwd_rt_d,
   output logic [1:0] fwd_rs_e,
   output logic [1:0] fwd_rt_e,
   output logic       fwd_rt_m,
   output logic       md_busy
);

   localparam logic [2:0] RES_NW  = 3'd0;
   localparam int         MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int         CNT_W   = $clog2(MAX_CYC + 1);
   localparam logic [CNT_W-1:0] MULT_LD = CNT_W'(MULT_CYCLES);
   localparam logic [CNT_W-1:0] DIV_LD  = CNT_W'(DIV_CYCLES);

   logic [4:0]       a3_p0, a3_p1, a3_p2;
   logic [2:0]       res_p0, res_p1, res_p2;
   logic [1:0]       md_op_p0;
   logic [CNT_W-1:0] cnt;
   logic             m_rs_e, m_rs_m, m_rs_w;
   logic             m_rt_e, m_rt_m, m_rt_w;
   logic             stall_rs, stall_rt;

   // Register 0 and non-writing instructions can never produce a match.
   function automatic logic tag_match(input logic [4:0] src, input logic [4:0] a3,
                                      input logic [2:0] res);
      return (src != 5'd0) && (src == a3) && (res != RES_NW);
   endfunction

   function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] val);
      return (val == '0) ? '0 : val - 1'b1;
   endfunction

   assign m_rs_e = tag_match(rs_d, a3_p0, res_p0);
   assign m_rs_m = tag_match(rs_d, a3_p1, res_p1);
   assign m_rs_w = tag_match(rs_d, a3_p2, res_p2);
   assign m_rt_e = tag_match(rt_d, a3_p0, res_p0);
   assign m_rt_m = tag_match(rt_d, a3_p1, res_p1);
   assign m_rt_w = tag_match(rt_d, a3_p2, res_p2);

   assign md_busy = (md_op_p0 != 2'd0) || (cnt != '0);
   assign stall   = stall_rs || stall_rt || (md_use_d && md_busy);

`ifdef HAZARD_FWD_EN
   localparam logic [2:0] RES_ALU = 3'd1;
   localparam logic [2:0] RES_DM  = 3'd2;

   logic [4:0] rs_p0, rt_p0, rt_p1;

   function automatic logic [1:0] tnew_e(input logic [2:0] res);
      case (res)
         RES_ALU: return 2'd1;
         RES_DM:  return 2'd2;
         default: return 2'd0;
      endcase
   endfunction

   function automatic logic [1:0] tnew_m(input logic [2:0] res);
      return (res == RES_DM) ? 2'd1 : 2'd0;
   endfunction

   // Nearest stage whose value is already computed wins.
   function automatic logic [1:0] sel_d(input logic me, input logic mm, input logic mw,
                                        input logic [2:0] re, input logic [2:0] rm);
      if (me && tnew_e(re) == 2'd0)      return 2'd1;
      else if (mm && tnew_m(rm) == 2'd0) return 2'd2;
      else if (mw)                       return 2'd3;
      else                               return 2'd0;
   endfunction

   function automatic logic [1:0] sel_e(input logic mm, input logic mw, input logic [2:0] rm);
      if (mm && tnew_m(rm) == 2'd0) return 2'd2;
      else if (mw)                  return 2'd3;
      else                          return 2'd0;
   endfunction

   assign stall_rs = (tuse_rs != 2'd3) &&
                     ((m_rs_e && (tnew_e(res_p0) > tuse_rs)) || (m_rs_m && (tnew_m(res_p1) > tuse_rs)));
   assign stall_rt = (tuse_rt != 2'd3) &&
                     ((m_rt_e && (tnew_e(res_p0) > tuse_rt)) || (m_rt_m && (tnew_m(res_p1) > tuse_rt)));

   assign fwd_rs_d = sel_d(m_rs_e, m_rs_m, m_rs_w, res_p0, res_p1);
   assign fwd_rt_d = sel_d(m_rt_e, m_rt_m, m_rt_w, res_p0, res_p1);
   assign fwd_rs_e = sel_e(tag_match(rs_p0, a3_p1, res_p1), tag_match(rs_p0, a3_p2, res_p2), res_p1);
   assign fwd_rt_e = sel_e(tag_match(rt_p0, a3_p1, res_p1), tag_match(rt_p0, a3_p2, res_p2), res_p1);
   assign fwd_rt_m = tag_match(rt_p1, a3_p2, res_p2);
`else
   assign stall_rs = (tuse_rs != 2'd3) && (m_rs_e || m_rs_m || m_rs_w);
   assign stall_rt = (tuse_rt != 2'd3) && (m_rt_e || m_rt_m || m_rt_w);

   assign fwd_rs_d = 2'd0;
   assign fwd_rt_d = 2'd0;
   assign fwd_rs_e = 2'd0;
   assign fwd_rt_e = 2'd0;
   assign fwd_rt_m = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         a3_p0    <= '0;
         a3_p1    <= '0;
         a3_p2    <= '0;
         res_p0   <= RES_NW;
         res_p1   <= RES_NW;
         res_p2   <= RES_NW;
         md_op_p0 <= '0;
         cnt      <= '0;
`ifdef HAZARD_FWD_EN
         rs_p0    <= '0;
         rt_p0    <= '0;
         rt_p1    <= '0;
`endif
      end else begin
         // D -> E: a stall turns the E slot into a bubble
         if (stall) begin
            a3_p0    <= '0;
            res_p0   <= RES_NW;
            md_op_p0 <= '0;
`ifdef HAZARD_FWD_EN
            rs_p0    <= '0;
            rt_p0    <= '0;
`endif
         end else begin
            a3_p0    <= a3_d;
            res_p0   <= res_d;
            md_op_p0 <= md_op_d;
`ifdef HAZARD_FWD_EN
            rs_p0    <= rs_d;
            rt_p0    <= rt_d;
`endif
         end
         // E -> M
         a3_p1  <= a3_p0;
         res_p1 <= res_p0;
`ifdef HAZARD_FWD_EN
         rt_p1  <= rt_p0;
`endif
         // M -> W
         a3_p2  <= a3_p1;
         res_p2 <= res_p1;
         // mult/div busy window starts when the op leaves E
         if (md_op_p0 == 2'd2)       cnt <= DIV_LD;
         else if (md_op_p0 != 2'd0)  cnt <= MULT_LD;
         else                        cnt <= sat_dec(cnt);
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed instruction sequences with hand-computed control outputs.
// Expected values follow the HAZARD_FWD_EN build setting used for the DUT.
module tb_hazard_ctrl;

   typedef struct packed {
      logic [4:0] rs;
      logic [4:0] rt;
      logic [4:0] a3;
      logic [1:0] tr;
      logic [1:0] tt;
      logic [2:0] res;
      logic [1:0] mdop;
      logic       mduse;
   } instr_t;

   logic       clk;
   logic       reset;
   logic [4:0] rs_d, rt_d, a3_d;
   logic [1:0] tuse_rs, tuse_rt;
   logic [2:0] res_d;
   logic [1:0] md_op_d;
   logic       md_use_d;
   logic       stall;
   logic [1:0] fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e;
   logic       fwd_rt_m;
   logic       md_busy;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [10:0] sb_exp[$];
   string       sb_nm[$];
   logic [10:0] exp_v, act_v;
   string       nm_v;

   instr_t NOP, LW8, ADDU10, ADDU9, BEQ9, JAL, JR31, ADDU11, SW11, WR0, RD0, DIV, MFLO, MULT, MFHI;
   logic [10:0] Z, ST, SB;

   hazard_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk(clk), .reset(reset),
      .rs_d(rs_d), .rt_d(rt_d), .a3_d(a3_d),
      .tuse_rs(tuse_rs), .tuse_rt(tuse_rt),
      .res_d(res_d), .md_op_d(md_op_d), .md_use_d(md_use_d),
      .stall(stall),
      .fwd_rs_d(fwd_rs_d), .fwd_rt_d(fwd_rt_d),
      .fwd_rs_e(fwd_rs_e), .fwd_rt_e(fwd_rt_e),
      .fwd_rt_m(fwd_rt_m), .md_busy(md_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic instr_t mk(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] a3,
                                 input logic [1:0] tr, input logic [1:0] tt, input logic [2:0] res,
                                 input logic [1:0] mdop, input logic mduse);
      instr_t i;
      i.rs = rs; i.rt = rt; i.a3 = a3; i.tr = tr; i.tt = tt;
      i.res = res; i.mdop = mdop; i.mduse = mduse;
      return i;
   endfunction

   // {stall, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m, md_busy}
   function automatic logic [10:0] ex(input logic s, input logic [1:0] frd, input logic [1:0] ftd,
                                      input logic [1:0] fre, input logic [1:0] fte,
                                      input logic frm, input logic b);
      return {s, frd, ftd, fre, fte, frm, b};
   endfunction

   task automatic drive(input logic rv, input instr_t i);
      reset = rv; rs_d = i.rs; rt_d = i.rt; a3_d = i.a3;
      tuse_rs = i.tr; tuse_rt = i.tt; res_d = i.res;
      md_op_d = i.mdop; md_use_d = i.mduse;
   endtask

   task automatic step(input logic rv, input instr_t i, input logic [10:0] e, input string nm);
      @(posedge clk);
      #1;
      drive(rv, i);
      sb_exp.push_back(e);
      sb_nm.push_back(nm);
   endtask

   always @(negedge clk) begin
      if (sb_exp.size() > 0) begin
         exp_v = sb_exp.pop_front();
         nm_v  = sb_nm.pop_front();
         act_v = {stall, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m, md_busy};
         n_checks++;
         if (act_v !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b", nm_v, act_v, exp_v);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      NOP    = mk(5'd0,  5'd0,  5'd0,  2'd3, 2'd3, 3'd0, 2'd0, 1'b0);
      LW8    = mk(5'd29, 5'd8,  5'd8,  2'd1, 2'd3, 3'd2, 2'd0, 1'b0);
      ADDU10 = mk(5'd8,  5'd0,  5'd10, 2'd1, 2'd1, 3'd1, 2'd0, 1'b0);
      ADDU9  = mk(5'd1,  5'd2,  5'd9,  2'd1, 2'd1, 3'd1, 2'd0, 1'b0);
      BEQ9   = mk(5'd9,  5'd0,  5'd0,  2'd0, 2'd0, 3'd0, 2'd0, 1'b0);
      JAL    = mk(5'd0,  5'd0,  5'd31, 2'd3, 2'd3, 3'd3, 2'd0, 1'b0);
      JR31   = mk(5'd31, 5'd0,  5'd0,  2'd0, 2'd3, 3'd0, 2'd0, 1'b0);
      ADDU11 = mk(5'd1,  5'd2,  5'd11, 2'd1, 2'd1, 3'd1, 2'd0, 1'b0);
      SW11   = mk(5'd29, 5'd11, 5'd0,  2'd1, 2'd2, 3'd0, 2'd0, 1'b0);
      WR0    = mk(5'd0,  5'd0,  5'd0,  2'd3, 2'd3, 3'd1, 2'd0, 1'b0);
      RD0    = mk(5'd0,  5'd0,  5'd5,  2'd0, 2'd0, 3'd1, 2'd0, 1'b0);
      DIV    = mk(5'd1,  5'd2,  5'd0,  2'd1, 2'd1, 3'd0, 2'd2, 1'b1);
      MFLO   = mk(5'd0,  5'd0,  5'd12, 2'd3, 2'd3, 3'd1, 2'd0, 1'b1);
      MULT   = mk(5'd1,  5'd2,  5'd0,  2'd1, 2'd1, 3'd0, 2'd1, 1'b1);
      MFHI   = mk(5'd0,  5'd0,  5'd13, 2'd3, 2'd3, 3'd1, 2'd0, 1'b1);
      Z  = ex(1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0);
      ST = ex(1'b1, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0);
      SB = ex(1'b1, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b1);

      drive(1'b1, NOP);
      step(1'b1, NOP, Z, "rst_hold0");
      step(1'b0, NOP, Z, "rst_hold1");

`ifdef HAZARD_FWD_EN
      step(1'b0, LW8,    Z,  "lw_issue");
      step(1'b0, ADDU10, ST, "lw_use_stall");
      step(1'b0, ADDU10, Z,  "lw_use_release");
      step(1'b0, NOP,    ex(1'b0, 2'd0, 2'd0, 2'd3, 2'd0, 1'b0, 1'b0), "lw_fwd_e_w");
      step(1'b0, ADDU9,  Z,  "addu9_issue");
      step(1'b0, BEQ9,   ST, "beq_stall");
      step(1'b0, BEQ9,   ex(1'b0, 2'd2, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0), "beq_fwd_d_m");
      step(1'b0, JAL,    ex(1'b0, 2'd0, 2'd0, 2'd3, 2'd0, 1'b0, 1'b0), "beq_fwd_e_w");
      step(1'b0, JR31,   ex(1'b0, 2'd1, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0), "jr_fwd_d_e");
      step(1'b0, NOP,    ex(1'b0, 2'd0, 2'd0, 2'd2, 2'd0, 1'b0, 1'b0), "jr_fwd_e_m");
      step(1'b0, NOP,    Z,  "idle0");
      step(1'b0, ADDU11, Z,  "addu11_issue");
      step(1'b0, SW11,   Z,  "sw_no_stall");
      step(1'b0, NOP,    ex(1'b0, 2'd0, 2'd0, 2'd0, 2'd2, 1'b0, 1'b0), "sw_fwd_e_m");
      step(1'b0, NOP,    ex(1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b1, 1'b0), "sw_fwd_m_w");
      step(1'b0, NOP,    Z,  "idle1");
`else
      step(1'b0, LW8,    Z,  "lw_issue");
      step(1'b0, ADDU10, ST, "lw_stall_e");
      step(1'b0, ADDU10, ST, "lw_stall_m");
      step(1'b0, ADDU10, ST, "lw_stall_w");
      step(1'b0, ADDU10, Z,  "lw_use_release");
      step(1'b0, NOP,    Z,  "addu10_e");
      step(1'b0, ADDU9,  Z,  "addu9_issue");
      step(1'b0, BEQ9,   ST, "beq_stall_e");
      step(1'b0, BEQ9,   ST, "beq_stall_m");
      step(1'b0, BEQ9,   ST, "beq_stall_w");
      step(1'b0, BEQ9,   Z,  "beq_release");
      step(1'b0, JAL,    Z,  "jal_issue");
      step(1'b0, JR31,   ST, "jr_stall_e");
      step(1'b0, JR31,   ST, "jr_stall_m");
      step(1'b0, JR31,   ST, "jr_stall_w");
      step(1'b0, JR31,   Z,  "jr_release");
      step(1'b0, NOP,    Z,  "idle0");
      step(1'b0, ADDU11, Z,  "addu11_issue");
      step(1'b0, SW11,   ST, "sw_stall_e");
      step(1'b0, SW11,   ST, "sw_stall_m");
      step(1'b0, SW11,   ST, "sw_stall_w");
      step(1'b0, SW11,   Z,  "sw_release");
      step(1'b0, NOP,    Z,  "idle1");
`endif

      step(1'b0, WR0, Z, "zero_writer");
      step(1'b0, RD0, Z, "zero_reader");
      step(1'b0, NOP, Z, "zero_idle");

      step(1'b0, DIV,  Z,  "div_issue");
      step(1'b0, MFLO, SB, "div_e_stall");
      repeat (10) step(1'b0, MFLO, SB, "div_busy");
      step(1'b0, MFLO, Z,  "div_release");
      step(1'b0, NOP,  Z,  "mflo_e");

      step(1'b0, DIV,  Z,  "div2_issue");
      step(1'b0, MFLO, SB, "div2_c1");
      step(1'b0, MFLO, SB, "div2_c2");
      step(1'b1, MFLO, SB, "div2_c3_reset");
      step(1'b0, MFLO, Z,  "div2_after_reset");
      step(1'b0, NOP,  Z,  "post_reset");

      step(1'b0, MULT, Z,  "mult_issue");
      step(1'b0, MFHI, SB, "mult_e_stall");
      repeat (5) step(1'b0, MFHI, SB, "mult_busy");
      step(1'b0, MFHI, Z,  "mult_release");
      step(1'b0, NOP,  Z,  "tail");

      @(negedge clk);
      @(negedge clk);
      n_checks++;
      if (sb_exp.size() != 0) begin
         n_errors++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_exp.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
